pixel_combinator: RTL and testbench
===================================

Name: pixel_combinator

Overview:
Read-side consumer for the per-engine pixel queues. It walks the frame in raster order and broadcasts the next expected coordinate to all queues. It pops the first queue whose head matches that coordinate and emits the colour as a valid/ready pixel stream with start-of-frame and end-of-line markers toward the video output. A stall timeout substitutes a fill pixel, so a lost engine result cannot hang the display.

Parameters:
NUM_QUEUES, 4, number of engine queues polled
DATA_WIDTH, 10, coordinate width
RGB_SIZE, 24, colour width
X_SIZE, 640, pixels per line
Y_SIZE, 480, lines per frame
STALL_LIMIT, 1023, cycles without any match before a fill pixel is emitted
FILL_COLOUR, 24'h000000, colour emitted on timeout

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
xpixel_check  output  DATA_WIDTH  expected x coordinate, broadcast to all queues
ypixel_check  output  DATA_WIDTH  expected y coordinate, broadcast to all queues
match_i  input  NUM_QUEUES  per-queue flag: head equals check coords and queue non-empty (combinational in queue)
colour_i  input  NUM_QUEUES*RGB_SIZE  per-queue head colour; queue k occupies bits [k*RGB_SIZE +: RGB_SIZE]
pop_o  output  NUM_QUEUES  one-hot, one-cycle pop strobe to the selected queue
out_data  output  RGB_SIZE  pixel colour
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts when valid & ready
out_sof  output  1  qualifies out_data as pixel (0,0)
out_eol  output  1  qualifies out_data as last pixel of a line (x = X_SIZE-1)
skip_o  output  1  one-cycle pulse when a fill pixel is substituted
stall_err  output  1  sticky; set on first skip, cleared only by reset

Behaviour:
- Reset values:
  - coords (0,0); out_valid 0; out_data 0; out_sof 0; out_eol 0.
  - pop_o 0; skip_o 0; stall_err 0; stall counter 0; state SEEK.
- Load condition: out register free, i.e. out_valid=0 or (out_valid & out_ready) in the same cycle.
- FSM, two states:
  - SEEK: waiting for a pixel. On load condition and |match_i:
    - sel = lowest index k with match_i[k];
    - pop_o[k]=1 for that cycle only;
    - out_data <= colour_i[sel];
    - out_sof/out_eol computed from the current coords;
    - coords advance; stall counter <= 0; state OUT.
  - OUT: out_valid=1, with out_data, out_sof and out_eol held stable until accepted.
    - On acceptance with |match_i: reload in the same cycle as in SEEK (full throughput, one pixel per cycle).
    - On acceptance without a match: out_valid <= 0; state SEEK.
- Stall counter:
  - Increments each cycle in which the load condition holds and match_i=0.
  - When it reaches STALL_LIMIT with the load condition true: load FILL_COLOUR, no pop, coords advance, skip_o=1 for one cycle, stall_err <= 1, counter <= 0.
- pop_o is combinational from state, match_i and out_ready. It never asserts while out_valid & ~out_ready, so queues are never popped while output is back-pressured.
- Multiple simultaneous matches (duplicate coordinate): only the lowest index is popped. Others stay at the head and are not matched again once coords move on. Allowed; no error flagged.
- Coordinate advance:
  - x+1; at x=X_SIZE-1, x<=0 and y+1.
  - At (X_SIZE-1, Y_SIZE-1), wrap to (0,0).
  - All arithmetic is modulo the wrap values, not modulo 2^DATA_WIDTH.
- Check coords are always the coordinate of the next pixel to be loaded, not the one currently in out_data.
- Latency: match seen in cycle n -> out_valid high in cycle n+1.
- Reset mid-frame: all state returns to reset values immediately. An unaccepted out_data is discarded; queue contents are not this block's concern.

Test Plan:
- X_SIZE=4, Y_SIZE=2, out_ready=1, queue0 matches each cycle with colour=x+16*y -> out_data 0x00,01,02,03,10,11,12,13 on consecutive cycles; out_sof only on the first; out_eol on 0x03 and 0x13; coords wrap to (0,0).
- match_i=4'b0110, colour1=0xAA, colour2=0xBB -> pop_o=4'b0010, out_data=0xAA, coords advance by exactly one.
- out_valid=1 with out_ready=0 for 5 cycles while match_i=1 -> pop_o stays 0, out_data/out_sof/out_eol stable; raise out_ready -> pop on that cycle, next pixel loaded the following cycle.
- STALL_LIMIT=8, match_i=0 for 8 cycles at (2,0) -> skip_o pulses once, out_data=FILL_COLOUR, stall_err=1, check coords become (3,0); subsequent match resumes normally and stall_err stays 1.
- Reset asserted at (3,1) with out_valid=1 -> next cycle out_valid=0, coords (0,0), pop_o=0, stall_err=0.
- Alternating match across queues 0..3 with random out_ready (50%) over 3 frames at 4x2 -> scoreboard receives every pixel once in raster order with no pops during back-pressure.

Source files
------------

// File: rtl/pixel_combinator_if.sv
// pixel_combinator_if: queue-side poll/pop bus and video-side valid/ready pixel stream
interface pixel_combinator_if #(
  parameter int NUM_QUEUES = 4,
  parameter int DATA_WIDTH = 10,
  parameter int RGB_SIZE = 24
);
  logic [DATA_WIDTH-1:0] xpixel_check;
  logic [DATA_WIDTH-1:0] ypixel_check;
  logic [NUM_QUEUES-1:0] match_i;
  logic [NUM_QUEUES*RGB_SIZE-1:0] colour_i;
  logic [NUM_QUEUES-1:0] pop_o;
  logic [RGB_SIZE-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic out_sof;
  logic out_eol;
  modport master (
    output xpixel_check, ypixel_check, pop_o, out_data, out_valid, out_sof, out_eol,
    input match_i, colour_i, out_ready
  );
  modport slave (
    input xpixel_check, ypixel_check, pop_o, out_data, out_valid, out_sof, out_eol,
    output match_i, colour_i, out_ready
  );
endinterface

// File: rtl/pixel_combinator.sv
// pixel_combinator: raster-order gatherer popping matching queue heads, fill pixel on stall
module pixel_combinator #(
  parameter int NUM_QUEUES = 4,
  parameter int DATA_WIDTH = 10,
  parameter int RGB_SIZE = 24,
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480,
  parameter int STALL_LIMIT = 1023,
  parameter logic [RGB_SIZE-1:0] FILL_COLOUR = '0
) (
  input logic clk,
  input logic reset,
  pixel_combinator_if.master bus,
  output logic skip_o,
  output logic stall_err
);
  localparam int CW = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0] STALL_LAST = CW'(STALL_LIMIT - 1);
  localparam logic [DATA_WIDTH-1:0] X_LAST = DATA_WIDTH'(X_SIZE - 1);
  localparam logic [DATA_WIDTH-1:0] Y_LAST = DATA_WIDTH'(Y_SIZE - 1);
  typedef enum logic {SEEK, OUT} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] x, y;
  logic [CW-1:0] stall_cnt;
  logic [NUM_QUEUES-1:0] sel;
  logic [RGB_SIZE-1:0] sel_colour;
  logic load, hit, timeout, x_last;
  assign load = (state == SEEK) || bus.out_ready;
  assign hit = |bus.match_i;
  assign timeout = !hit && stall_cnt == STALL_LAST;
  // lowest set bit wins when a coordinate was queued twice
  assign sel = bus.match_i & (~bus.match_i + NUM_QUEUES'(1));
  assign x_last = x == X_LAST;
  always_comb begin
    sel_colour = '0;
    for (int k = 0; k < NUM_QUEUES; k++)
      sel_colour = sel_colour | ({RGB_SIZE{sel[k]}} & bus.colour_i[k*RGB_SIZE +: RGB_SIZE]);
  end
  assign bus.pop_o = load ? sel : '0;
  assign bus.out_valid = state == OUT;
  assign bus.xpixel_check = x;
  assign bus.ypixel_check = y;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEEK;
      x <= '0;
      y <= '0;
      stall_cnt <= '0;
      bus.out_data <= '0;
      bus.out_sof <= 1'b0;
      bus.out_eol <= 1'b0;
      skip_o <= 1'b0;
      stall_err <= 1'b0;
    end else begin
      skip_o <= 1'b0;
      if (load && (hit || timeout)) begin
        bus.out_data <= hit ? sel_colour : FILL_COLOUR;
        bus.out_sof <= x == '0 && y == '0;
        bus.out_eol <= x_last;
        x <= x_last ? '0 : x + DATA_WIDTH'(1);
        y <= x_last ? (y == Y_LAST ? '0 : y + DATA_WIDTH'(1)) : y;
        stall_cnt <= '0;
        state <= OUT;
        skip_o <= !hit;
        stall_err <= stall_err | !hit;
      end else if (load) begin
        stall_cnt <= stall_cnt + CW'(1);
        state <= SEEK;
      end
    end
  end
endmodule

// File: tb/tb_pixel_combinator.sv
// tb_pixel_combinator: directed scenarios plus randomized queue/back-pressure run on a 4x2 frame
module tb_pixel_combinator;
  localparam int NQ = 4, DW = 10, RGB = 24, XS = 4, YS = 2, SL = 8;
  localparam logic [RGB-1:0] FILL = 24'hC0FFEE;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic skip_o, stall_err;
  int errors = 0, checks = 0;
  pixel_combinator_if #(.NUM_QUEUES(NQ), .DATA_WIDTH(DW), .RGB_SIZE(RGB)) bus ();
  pixel_combinator #(
    .NUM_QUEUES(NQ), .DATA_WIDTH(DW), .RGB_SIZE(RGB), .X_SIZE(XS), .Y_SIZE(YS),
    .STALL_LIMIT(SL), .FILL_COLOUR(FILL)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .skip_o(skip_o), .stall_err(stall_err)
  );
  always #5 clk = ~clk;

  task automatic rst_dut();
    reset = 1'b1;
    bus.match_i = '0;
    bus.colour_i = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.match_i = '0;
    bus.colour_i = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out_sof, bus.out_eol, bus.out_data, bus.pop_o, skip_o, stall_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs valid=%b sof=%b eol=%b data=%h pop=%b skip=%b err=%b want all 0",
               bus.out_valid, bus.out_sof, bus.out_eol, bus.out_data, bus.pop_o, skip_o, stall_err);
    end
    checks++;
    if ({bus.xpixel_check, bus.ypixel_check} !== '0) begin
      errors++;
      $display("FAIL reset_coords got=(%0d,%0d) want=(0,0)", bus.xpixel_check, bus.ypixel_check);
    end
    reset = 1'b0;
  endtask

  task automatic test_raster();
    int p;
    rst_dut();
    for (int i = 0; i <= 8; i++) begin
      checks++;
      if ({bus.xpixel_check, bus.ypixel_check} !== {DW'(i % XS), DW'((i / XS) % YS)}) begin
        errors++;
        $display("FAIL raster_coords i=%0d got=(%0d,%0d) want=(%0d,%0d)", i,
                 bus.xpixel_check, bus.ypixel_check, i % XS, (i / XS) % YS);
      end
      if (i > 0) begin
        p = i - 1;
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_sof, bus.out_eol} !==
            {1'b1, RGB'(p % XS + 16 * (p / XS)), p == 0, (p % XS) == XS - 1}) begin
          errors++;
          $display("FAIL raster_pixel p=%0d got v=%b d=%h sof=%b eol=%b want d=%h sof=%b eol=%b", p,
                   bus.out_valid, bus.out_data, bus.out_sof, bus.out_eol,
                   p % XS + 16 * (p / XS), p == 0, (p % XS) == XS - 1);
        end
      end
      bus.match_i = (i < 8) ? 4'b0001 : 4'b0000;
      bus.colour_i = '0;
      bus.colour_i[RGB-1:0] = RGB'(i % XS + 16 * (i / XS));
      #1;
      checks++;
      if (bus.pop_o !== ((i < 8) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL raster_pop i=%0d got=%b want=%b", i, bus.pop_o, (i < 8) ? 4'b0001 : 4'b0000);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL raster_drain got valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_priority();
    rst_dut();
    bus.match_i = 4'b0110;
    bus.colour_i = {24'h333333, 24'h0000BB, 24'h0000AA, 24'h111111};
    #1;
    checks++;
    if (bus.pop_o !== 4'b0010) begin
      errors++;
      $display("FAIL priority_pop got=%b want=0010", bus.pop_o);
    end
    @(negedge clk);
    bus.match_i = '0;
    checks++;
    if ({bus.out_valid, bus.out_data} !== {1'b1, 24'h0000AA}) begin
      errors++;
      $display("FAIL priority_data got v=%b d=%h want v=1 d=0000aa", bus.out_valid, bus.out_data);
    end
    checks++;
    if ({bus.xpixel_check, bus.ypixel_check} !== {DW'(1), DW'(0)}) begin
      errors++;
      $display("FAIL priority_coords got=(%0d,%0d) want=(1,0)", bus.xpixel_check, bus.ypixel_check);
    end
  endtask

  task automatic test_backpressure();
    rst_dut();
    bus.match_i = 4'b0001;
    bus.colour_i = '0;
    bus.colour_i[RGB-1:0] = 24'h0000C0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.colour_i[RGB-1:0] = 24'h0000C1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (bus.pop_o !== 4'b0000) begin
        errors++;
        $display("FAIL bp_pop c=%0d got=%b want=0000", c, bus.pop_o);
      end
      checks++;
      if ({bus.out_valid, bus.out_data, bus.out_sof, bus.out_eol, bus.xpixel_check, bus.ypixel_check} !==
          {1'b1, 24'h0000C0, 1'b1, 1'b0, DW'(1), DW'(0)}) begin
        errors++;
        $display("FAIL bp_hold c=%0d got v=%b d=%h sof=%b eol=%b xy=(%0d,%0d) want v=1 d=c0 sof=1 eol=0 xy=(1,0)",
                 c, bus.out_valid, bus.out_data, bus.out_sof, bus.out_eol, bus.xpixel_check, bus.ypixel_check);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.pop_o !== 4'b0001) begin
      errors++;
      $display("FAIL bp_release_pop got=%b want=0001", bus.pop_o);
    end
    @(negedge clk);
    bus.match_i = '0;
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_sof, bus.xpixel_check, bus.ypixel_check} !==
        {1'b1, 24'h0000C1, 1'b0, DW'(2), DW'(0)}) begin
      errors++;
      $display("FAIL bp_next got v=%b d=%h sof=%b xy=(%0d,%0d) want v=1 d=c1 sof=0 xy=(2,0)",
               bus.out_valid, bus.out_data, bus.out_sof, bus.xpixel_check, bus.ypixel_check);
    end
  endtask

  task automatic test_stall();
    rst_dut();
    bus.match_i = 4'b0001;
    bus.colour_i = '0;
    bus.colour_i[RGB-1:0] = 24'h000001;
    @(negedge clk);
    bus.colour_i[RGB-1:0] = 24'h000002;
    @(negedge clk);
    bus.match_i = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      checks++;
      if ({skip_o, stall_err} !== {c == SL, c >= SL}) begin
        errors++;
        $display("FAIL stall_flags c=%0d got skip=%b err=%b want skip=%b err=%b",
                 c, skip_o, stall_err, c == SL, c >= SL);
      end
      if (c == SL) begin
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_eol, bus.xpixel_check, bus.ypixel_check} !==
            {1'b1, FILL, 1'b0, DW'(3), DW'(0)}) begin
          errors++;
          $display("FAIL stall_fill got v=%b d=%h eol=%b xy=(%0d,%0d) want v=1 d=%h eol=0 xy=(3,0)",
                   bus.out_valid, bus.out_data, bus.out_eol, bus.xpixel_check, bus.ypixel_check, FILL);
        end
      end
    end
    bus.match_i = 4'b0001;
    bus.colour_i[RGB-1:0] = 24'h000055;
    #1;
    checks++;
    if (bus.pop_o !== 4'b0001) begin
      errors++;
      $display("FAIL stall_resume_pop got=%b want=0001", bus.pop_o);
    end
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_eol, skip_o, stall_err, bus.xpixel_check, bus.ypixel_check} !==
        {1'b1, 24'h000055, 1'b1, 1'b0, 1'b1, DW'(0), DW'(1)}) begin
      errors++;
      $display("FAIL stall_resume got v=%b d=%h eol=%b skip=%b err=%b xy=(%0d,%0d) want v=1 d=55 eol=1 skip=0 err=1 xy=(0,1)",
               bus.out_valid, bus.out_data, bus.out_eol, skip_o, stall_err, bus.xpixel_check, bus.ypixel_check);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      bus.colour_i[RGB-1:0] = RGB'(24'h000060 + i);
      @(negedge clk);
    end
    bus.match_i = '0;
    bus.out_ready = 1'b0;
    checks++;
    if ({bus.out_valid, stall_err, bus.xpixel_check, bus.ypixel_check} !== {1'b1, 1'b1, DW'(3), DW'(1)}) begin
      errors++;
      $display("FAIL midreset_pre got v=%b err=%b xy=(%0d,%0d) want v=1 err=1 xy=(3,1)",
               bus.out_valid, stall_err, bus.xpixel_check, bus.ypixel_check);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if ({bus.out_valid, bus.pop_o, stall_err, bus.xpixel_check, bus.ypixel_check} !== '0) begin
      errors++;
      $display("FAIL midreset_post got v=%b pop=%b err=%b xy=(%0d,%0d) want all 0",
               bus.out_valid, bus.pop_o, stall_err, bus.xpixel_check, bus.ypixel_check);
    end
  endtask

  task automatic test_random();
    localparam int NPIX = 3 * XS * YS;
    logic [RGB-1:0] col [NPIX];
    int hp [NQ];
    int loaded = 0, rx = 0, streak = 0, cyc = 0, p;
    logic [NQ-1:0] m, pp;
    logic [NQ*RGB-1:0] cdata;
    logic v, r, s, e;
    logic [RGB-1:0] d;
    for (int i = 0; i < NPIX; i++) col[i] = RGB'($urandom);
    for (int k = 0; k < NQ; k++) hp[k] = 0;
    rst_dut();
    while (rx < NPIX && cyc < 2000) begin
      cyc++;
      checks++;
      if ({bus.xpixel_check, bus.ypixel_check} !== {DW'(loaded % XS), DW'((loaded / XS) % YS)}) begin
        errors++;
        $display("FAIL rand_coords loaded=%0d got=(%0d,%0d) want=(%0d,%0d)", loaded,
                 bus.xpixel_check, bus.ypixel_check, loaded % XS, (loaded / XS) % YS);
      end
      m = '0;
      cdata = '0;
      for (int k = 0; k < NQ; k++) begin
        p = NQ * hp[k] + k;
        if (p < NPIX) begin
          cdata[k*RGB +: RGB] = col[p];
          if (DW'(p % XS) == bus.xpixel_check && DW'((p / XS) % YS) == bus.ypixel_check &&
              ($urandom_range(0, 3) != 0 || streak >= 4))
            m[k] = 1'b1;
        end
      end
      streak = (m == '0) ? streak + 1 : 0;
      bus.match_i = m;
      bus.colour_i = cdata;
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      v = bus.out_valid;
      r = bus.out_ready;
      pp = bus.pop_o;
      d = bus.out_data;
      s = bus.out_sof;
      e = bus.out_eol;
      checks++;
      if (pp !== ((!v || r) ? m : '0)) begin
        errors++;
        $display("FAIL rand_pop cyc=%0d got=%b want=%b (valid=%b ready=%b)", cyc, pp, (!v || r) ? m : '0, v, r);
      end
      @(posedge clk);
      if (v && r) begin
        checks++;
        if ({d, s, e} !== {col[rx], rx % (XS * YS) == 0, rx % XS == XS - 1}) begin
          errors++;
          $display("FAIL rand_pixel n=%0d got d=%h sof=%b eol=%b want d=%h sof=%b eol=%b", rx,
                   d, s, e, col[rx], rx % (XS * YS) == 0, rx % XS == XS - 1);
        end
        rx++;
      end
      if (pp != '0) begin
        for (int k = 0; k < NQ; k++) if (pp[k]) hp[k]++;
        loaded++;
      end
      @(negedge clk);
    end
    bus.match_i = '0;
    checks++;
    if (rx != NPIX) begin
      errors++;
      $display("FAIL rand_timeout received=%0d want=%0d", rx, NPIX);
    end
    checks++;
    if (stall_err !== 1'b0) begin
      errors++;
      $display("FAIL rand_stall_err got=%b want=0", stall_err);
    end
  endtask

  initial begin
    bus.match_i = '0;
    bus.colour_i = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_raster();
    test_priority();
    test_backpressure();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
